// File: rtl/branch_sequencer_if.sv
// Purpose: bundle of the branch sequencer's control/handshake signals.
//   master : main control / ALU / gate side (drives requests, flags, gate_out)
//   slave  : branch_sequencer (drives ALU/gate/PC controls and status)
// Signals:
//   start, opcode, imm16, pc_plus4          : branch request and instruction fields
//   cmp_valid, igual, maior, menor          : ALU compare flags
//   gate_out                                : condition gate result
//   reg_read_en, alu_cmp_req                : register-file / ALU controls
//   uc_control, uc_op                       : condition gate controls
//   pc_write, pc_target                     : PC load strobe and target
//   busy, done, taken, error                : status
interface branch_sequencer_if;
  localparam int unsigned OPC_W  = 6;
  localparam int unsigned IMM_W  = 16;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned UOP_W  = 2;

  logic              start;
  logic [OPC_W-1:0]  opcode;
  logic [IMM_W-1:0]  imm16;
  logic [ADDR_W-1:0] pc_plus4;
  logic              cmp_valid;
  logic              igual;
  logic              maior;
  logic              menor;
  logic              gate_out;

  logic              reg_read_en;
  logic              alu_cmp_req;
  logic              uc_control;
  logic [UOP_W-1:0]  uc_op;
  logic              pc_write;
  logic [ADDR_W-1:0] pc_target;
  logic              busy;
  logic              done;
  logic              taken;
  logic              error;

  modport master (
    output start, opcode, imm16, pc_plus4, cmp_valid, igual, maior, menor, gate_out,
    input  reg_read_en, alu_cmp_req, uc_control, uc_op, pc_write, pc_target,
           busy, done, taken, error
  );

  modport slave (
    input  start, opcode, imm16, pc_plus4, cmp_valid, igual, maior, menor, gate_out,
    output reg_read_en, alu_cmp_req, uc_control, uc_op, pc_write, pc_target,
           busy, done, taken, error
  );
endinterface

// File: rtl/branch_sequencer.sv
// Purpose: multicycle sequencer for conditional branches (BEQ/BNE/BLE/BGT).
//   Latches the instruction fields, computes the target, waits for an ALU
//   compare (with timeout), drives the condition gate and issues one PC write
//   when the branch is taken.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : branch_sequencer_if.slave (request, flags, gate and PC controls)
module branch_sequencer #(
  parameter int unsigned CMP_TIMEOUT = 8,
  parameter logic [5:0]  OP_BEQ      = 6'h04,
  parameter logic [5:0]  OP_BNE      = 6'h05,
  parameter logic [5:0]  OP_BLE      = 6'h06,
  parameter logic [5:0]  OP_BGT      = 6'h07
) (
  input  logic                clk,
  input  logic                reset,
  branch_sequencer_if.slave   bus
);

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned IMM_W  = 16;
  localparam int unsigned UOP_W  = 2;
  localparam int unsigned CNT_W  = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TARGET,
    S_COMPARE,
    S_RESOLVE,
    S_WRITE
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [UOP_W-1:0]   r_op;
  logic [IMM_W-1:0]   r_imm;
  logic [ADDR_W-1:0]  r_pc_l;
  logic [2:0]         r_flags;

  logic               r_reg_read_en;
  logic               r_alu_cmp_req;
  logic               r_uc_control;
  logic [UOP_W-1:0]   r_uc_op;
  logic               r_pc_write;
  logic [ADDR_W-1:0]  r_pc_target;
  logic               r_busy;
  logic               r_done;
  logic               r_taken;
  logic               r_error;

  logic               w_legal;
  logic [UOP_W-1:0]   w_op;
  logic               w_timeout;
  logic               w_flags_unused;

  // Opcode to gate-op decode
  always_comb begin
    w_legal = 1'b0;
    w_op    = '0;
    if (bus.opcode == OP_BEQ) begin
      w_legal = 1'b1;
      w_op    = 2'b00;
    end else if (bus.opcode == OP_BNE) begin
      w_legal = 1'b1;
      w_op    = 2'b01;
    end else if (bus.opcode == OP_BLE) begin
      w_legal = 1'b1;
      w_op    = 2'b10;
    end else if (bus.opcode == OP_BGT) begin
      w_legal = 1'b1;
      w_op    = 2'b11;
    end
  end

  // This missed compare cycle would be the CMP_TIMEOUT-th one
  assign w_timeout = ((9'(r_cnt) + 9'd1) == 9'(CMP_TIMEOUT));

  // Captured flags are kept for observability; the external gate makes the decision
  assign w_flags_unused = ^r_flags;

  // Sequencer state and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_op          <= '0;
      r_imm         <= '0;
      r_pc_l        <= '0;
      r_flags       <= '0;
      r_reg_read_en <= 1'b0;
      r_alu_cmp_req <= 1'b0;
      r_uc_control  <= 1'b0;
      r_uc_op       <= '0;
      r_pc_write    <= 1'b0;
      r_pc_target   <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_taken       <= 1'b0;
      r_error       <= 1'b0;
    end else begin
      // single-cycle strobes default low
      r_reg_read_en <= 1'b0;
      r_alu_cmp_req <= 1'b0;
      r_uc_control  <= 1'b0;
      r_uc_op       <= '0;
      r_pc_write    <= 1'b0;
      r_done        <= 1'b0;
      r_error       <= 1'b0;

      unique case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            if (w_legal) begin
              r_imm         <= bus.imm16;
              r_pc_l        <= bus.pc_plus4;
              r_op          <= w_op;
              r_taken       <= 1'b0;
              r_busy        <= 1'b1;
              r_reg_read_en <= 1'b1;
              r_state       <= S_TARGET;
            end else begin
              r_error <= 1'b1;
            end
          end
        end

        S_TARGET: begin
          // sign-extended word offset, wraps modulo 2^32
          r_pc_target   <= r_pc_l + {{14{r_imm[15]}}, r_imm, 2'b00};
          r_cnt         <= '0;
          r_alu_cmp_req <= 1'b1;
          r_state       <= S_COMPARE;
        end

        S_COMPARE: begin
          if (bus.cmp_valid) begin
            // cmp_valid wins even on the timeout cycle
            r_flags      <= {bus.igual, bus.maior, bus.menor};
            r_uc_control <= 1'b1;
            r_uc_op      <= r_op;
            r_state      <= S_RESOLVE;
          end else if (w_timeout) begin
            r_error <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_cnt         <= r_cnt + CNT_W'(1);
            r_alu_cmp_req <= 1'b1;
          end
        end

        S_RESOLVE: begin
          r_taken    <= bus.gate_out;
          r_pc_write <= bus.gate_out;
          r_done     <= 1'b1;
          r_state    <= S_WRITE;
        end

        S_WRITE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.reg_read_en = r_reg_read_en;
  assign bus.alu_cmp_req = r_alu_cmp_req;
  assign bus.uc_control  = r_uc_control;
  assign bus.uc_op       = r_uc_op;
  assign bus.pc_write    = r_pc_write;
  assign bus.pc_target   = r_pc_target;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.taken       = r_taken;
  assign bus.error       = r_error;

endmodule

// File: tb/tb_branch_sequencer.sv
// Purpose: self-checking bench for branch_sequencer; directed cases plus
//   randomized branches checked against a transaction-level reference model.
module tb_branch_sequencer;
  localparam int unsigned T = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  branch_sequencer_if bus();

  branch_sequencer #(.CMP_TIMEOUT(T)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // true compare result of the current branch (what the ALU would hold)
  logic m_eq, m_gt, m_lt;
  logic m_taken;
  bit   m_taken_known;

  // condition gate model: evaluates the selected condition on the true flags
  function automatic logic gate_fn(input logic [1:0] op, input logic eq, gt, lt);
    case (op)
      2'b00:   return eq;
      2'b01:   return !eq;
      2'b10:   return eq | lt;
      default: return gt;
    endcase
  endfunction

  assign bus.gate_out = bus.uc_control & gate_fn(bus.uc_op, m_eq, m_gt, m_lt);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble();
    bus.opcode   = 6'($urandom);
    bus.imm16    = 16'($urandom);
    bus.pc_plus4 = $urandom;
    bus.igual    = 1'($urandom);
    bus.maior    = 1'($urandom);
    bus.menor    = 1'($urandom);
  endtask

  function automatic logic [1:0] exp_uop(input logic [5:0] opc);
    case (opc)
      6'h04:   return 2'd0;
      6'h05:   return 2'd1;
      6'h06:   return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  function automatic logic exp_branch(input logic [5:0] opc, input logic [31:0] a, b);
    case (opc)
      6'h04:   return a == b;
      6'h05:   return a != b;
      6'h06:   return $signed(a) <= $signed(b);
      default: return $signed(a) > $signed(b);
    endcase
  endfunction

  // One branch transaction; lat = compare cycle carrying cmp_valid (>T means never)
  task automatic run_branch(input logic [5:0] opc, input logic [15:0] imm,
                            input logic [31:0] pc, input int lat,
                            input logic [31:0] a, input logic [31:0] b, input bit poke);
    logic [31:0] exp_tgt;
    logic        exp_tk;
    bit          resolved;
    exp_tgt  = pc + 32'(int'($signed(imm)) * 4);
    exp_tk   = exp_branch(opc, a, b);
    m_eq     = (a == b);
    m_gt     = ($signed(a) > $signed(b));
    m_lt     = ($signed(a) < $signed(b));
    resolved = 0;

    bus.start = 1'b1; bus.opcode = opc; bus.imm16 = imm; bus.pc_plus4 = pc;
    step();
    bus.start = 1'b0;
    scramble();
    check("tgt_busy", 32'(bus.busy), 32'd1);
    check("tgt_rden", 32'(bus.reg_read_en), 32'd1);
    check("tgt_cmpreq", 32'(bus.alu_cmp_req), 32'd0);
    if (poke) begin
      bus.start = 1'b1; bus.opcode = 6'h04;
    end
    step();
    bus.start = 1'b0;
    check("pc_target", bus.pc_target, exp_tgt);
    check("cmp_rden", 32'(bus.reg_read_en), 32'd0);

    for (int k = 1; k <= int'(T); k++) begin
      check("cmp_req", 32'(bus.alu_cmp_req), 32'd1);
      check("cmp_uc", 32'(bus.uc_control), 32'd0);
      check("cmp_err", 32'(bus.error), 32'd0);
      bus.cmp_valid = (k == lat);
      if (k == lat) begin
        bus.igual = m_eq; bus.maior = m_gt; bus.menor = m_lt;
      end else begin
        scramble();
      end
      if (poke && k == 1) begin
        bus.start = 1'b1; bus.opcode = 6'h04;
      end
      step();
      bus.cmp_valid = 1'b0;
      bus.start     = 1'b0;
      if (k == lat) begin
        resolved = 1;
        break;
      end
    end

    if (!resolved) begin
      check("to_error", 32'(bus.error), 32'd1);
      check("to_busy", 32'(bus.busy), 32'd0);
      check("to_done", 32'(bus.done), 32'd0);
      check("to_pcw", 32'(bus.pc_write), 32'd0);
      step();
      check("to_err_pulse", 32'(bus.error), 32'd0);
      check("to_idle_busy", 32'(bus.busy), 32'd0);
      check("to_idle_done", 32'(bus.done), 32'd0);
      m_taken_known = 0;
      return;
    end

    check("res_uc", 32'(bus.uc_control), 32'd1);
    check("res_uop", 32'(bus.uc_op), 32'(exp_uop(opc)));
    check("res_cmpreq", 32'(bus.alu_cmp_req), 32'd0);
    check("res_done", 32'(bus.done), 32'd0);
    step();
    check("wr_done", 32'(bus.done), 32'd1);
    check("wr_pcw", 32'(bus.pc_write), 32'(exp_tk));
    check("wr_taken", 32'(bus.taken), 32'(exp_tk));
    check("wr_uc", 32'(bus.uc_control), 32'd0);
    m_taken = exp_tk;
    m_taken_known = 1;
    step();
    check("end_done", 32'(bus.done), 32'd0);
    check("end_pcw", 32'(bus.pc_write), 32'd0);
    check("end_busy", 32'(bus.busy), 32'd0);
    check("end_taken", 32'(bus.taken), 32'(m_taken));
  endtask

  task automatic run_illegal(input logic [5:0] opc);
    bus.start = 1'b1; bus.opcode = opc;
    step();
    bus.start = 1'b0;
    check("ill_error", 32'(bus.error), 32'd1);
    check("ill_busy", 32'(bus.busy), 32'd0);
    check("ill_rden", 32'(bus.reg_read_en), 32'd0);
    step();
    check("ill_err_pulse", 32'(bus.error), 32'd0);
    check("ill_busy2", 32'(bus.busy), 32'd0);
    if (m_taken_known) check("ill_taken", 32'(bus.taken), 32'(m_taken));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rden"}, 32'(bus.reg_read_en), 32'd0);
    check({tag, "_cmpreq"}, 32'(bus.alu_cmp_req), 32'd0);
    check({tag, "_uc"}, 32'(bus.uc_control), 32'd0);
    check({tag, "_uop"}, 32'(bus.uc_op), 32'd0);
    check({tag, "_pcw"}, 32'(bus.pc_write), 32'd0);
    check({tag, "_tgt"}, bus.pc_target, 32'd0);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_done"}, 32'(bus.done), 32'd0);
    check({tag, "_taken"}, 32'(bus.taken), 32'd0);
    check({tag, "_err"}, 32'(bus.error), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0]  opc;
    logic [31:0] a, b;
    reset = 1'b0;
    bus.start = 1'b0; bus.cmp_valid = 1'b0;
    bus.opcode = '0; bus.imm16 = '0; bus.pc_plus4 = '0;
    bus.igual = 1'b0; bus.maior = 1'b0; bus.menor = 1'b0;
    m_eq = 0; m_gt = 0; m_lt = 0; m_taken = 0; m_taken_known = 1;
    step(); step();
    check_all_zero("rst");
    reset = 1'b1;
    step();

    // BEQ taken, BNE not taken with negative offset
    run_branch(6'h04, 16'h0003, 32'h0000_0100, 1, 32'd5, 32'd5, 0);
    run_branch(6'h05, 16'hFFFF, 32'h0000_0200, 1, 32'd9, 32'd9, 0);
    // BGT timeout, then cmp_valid on the last allowed cycle
    run_branch(6'h07, 16'h0010, 32'h0000_1000, int'(T) + 1, 32'd7, 32'd3, 0);
    run_branch(6'h07, 16'h0010, 32'h0000_1000, int'(T), 32'd7, 32'd3, 0);
    // illegal opcode; BLE with start pulses while busy
    run_illegal(6'h23);
    run_branch(6'h06, 16'h0004, 32'h0000_0300, 2, 32'hFFFF_FFF0, 32'd1, 1);

    // reset during COMPARE clears everything asynchronously
    m_eq = 0; m_gt = 1; m_lt = 0;
    bus.start = 1'b1; bus.opcode = 6'h06; bus.imm16 = 16'h0002; bus.pc_plus4 = 32'h40;
    step();
    bus.start = 1'b0;
    step();
    check("mid_cmpreq", 32'(bus.alu_cmp_req), 32'd1);
    #2 reset = 1'b0;
    #1 check_all_zero("async_rst");
    step();
    reset = 1'b1;
    m_taken = 0; m_taken_known = 1;
    run_branch(6'h07, 16'h0001, 32'h0000_0800, 1, 32'd100, 32'd2, 0);

    // target wrap
    run_branch(6'h04, 16'h0001, 32'hFFFF_FFFC, 1, 32'd1, 32'd2, 0);

    // randomized branches
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        do opc = 6'($urandom); while (opc >= 6'h04 && opc <= 6'h07);
        run_illegal(opc);
      end else begin
        opc = 6'h04 + 6'($urandom_range(0, 3));
        a   = $urandom;
        b   = ($urandom_range(0, 2) == 0) ? a : $urandom;
        run_branch(opc, 16'($urandom), $urandom, int'($urandom_range(1, T + 1)),
                   a, b, bit'($urandom_range(0, 1)));
      end
      repeat ($urandom_range(0, 2)) step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
